// File: rtl/adder_tree_pkg.sv
// Shared constants and types for the 37-input adder tree datapath.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package adder_tree_pkg;

  localparam int N_IN  = 37;  // tree inputs == bytes per frame
  localparam int IN_W  = 8;   // byte width
  localparam int SUM_W = 14;  // clog2(37*255+1), width of the tree sum

  typedef enum logic {
    COLLECT = 1'b0,  // gathering a frame
    DRAIN   = 1'b1   // dropping bytes of an over-long frame until s_last
  } state_e;

endpackage

// File: rtl/adder_tree_feeder.sv
// Stream-to-vector front end: collects N_IN framed bytes, presents them in parallel to the adder tree.
// Latency: o_valid / err_len pulse one cycle after the frame's deciding byte is accepted.
// Backpressure: none toward the tree; s_ready is high whenever out of reset (1 byte/clk sustained).
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   s_valid/s_data/s_last/s_ready   upstream byte stream (transfer on s_valid & s_ready)
//   o_valid, o_vec      one-cycle frame pulse + held frame vector (byte k at o_vec[k*IN_W +: IN_W])
//   err_len             one-cycle pulse on a short or long frame
module adder_tree_feeder #(
  parameter int N_IN = adder_tree_pkg::N_IN,
  parameter int IN_W = adder_tree_pkg::IN_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  input  logic [IN_W-1:0]      s_data,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic                 o_valid,
  output logic [N_IN*IN_W-1:0] o_vec,
  output logic                 err_len
);

  import adder_tree_pkg::*;

  localparam int              IDX_W    = $clog2(N_IN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   s_ready_q;
  logic                   o_valid_q, o_valid_d;
  logic                   err_len_q, err_len_d;
  logic [N_IN*IN_W-1:0]   o_vec_q;
  logic [IN_W-1:0]        frame_q [N_IN];
  logic                   accept;
  logic                   wr_en;
  logic                   commit;

  assign accept = s_valid & s_ready_q;

  // Next-state / control decode
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    o_valid_d = 1'b0;
    err_len_d = 1'b0;
    wr_en     = 1'b0;
    commit    = 1'b0;
    if (accept) begin
      case (state_q)
        COLLECT: begin
          wr_en = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (s_last) begin
              commit    = 1'b1;
              o_valid_d = 1'b1;
            end else begin
              // Over-long frame: flag once, then swallow the rest of it.
              err_len_d = 1'b1;
              state_d   = DRAIN;
            end
          end else if (s_last) begin
            err_len_d = 1'b1;
            idx_d     = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        DRAIN: begin
          if (s_last) begin
            state_d = COLLECT;
          end
        end
      endcase
    end
  end

  // Control state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= COLLECT;
      idx_q     <= '0;
      s_ready_q <= 1'b0;
      o_valid_q <= 1'b0;
      err_len_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      s_ready_q <= 1'b1;
      o_valid_q <= o_valid_d;
      err_len_q <= err_len_d;
    end
  end

  // Frame buffer: no reset needed, every slot is rewritten before it is committed.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      frame_q[idx_q] <= s_data;
    end
  end

  // Output register is separate from the frame buffer so a frame in progress
  // never disturbs the last committed vector. The final byte bypasses the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_vec_q <= '0;
    end else if (commit) begin
      for (int k = 0; k < N_IN - 1; k++) begin
        o_vec_q[k*IN_W +: IN_W] <= frame_q[k];
      end
      o_vec_q[(N_IN-1)*IN_W +: IN_W] <= s_data;
    end
  end

  assign s_ready = s_ready_q;
  assign o_valid = o_valid_q;
  assign err_len = err_len_q;
  assign o_vec   = o_vec_q;

endmodule

// File: doc/adder_tree_feeder.md
# adder_tree_feeder

Stream-to-vector front end for the 37-input adder tree. Accepts framed 8-bit bytes one per cycle, collects exactly 37 of them into a frame buffer, then presents all 37 in parallel with a single-cycle valid pulse that drives the tree's `din_valid` / `i_0..i_36` inputs. Malformed frames (wrong length) are flagged and discarded, so the tree only ever sees complete frames. It sits between the upstream byte source and `AdderTree` in the accumulation datapath.

## Interface
Parameters:
- `N_IN`, 37: bytes per frame; equals the tree input count.
- `IN_W`, 8: byte width.

Ports:
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `s_valid`  in  1  upstream byte valid.
- `s_data`  in  IN_W  upstream byte.
- `s_last`  in  1  marks the final byte of a frame.
- `s_ready`  out  1  feeder accepts a byte; a transfer occurs when `s_valid & s_ready`.
- `o_valid`  out  1  one-cycle pulse; connects to the tree's `din_valid`.
- `o_vec`  out  N_IN*IN_W  frame vector; byte k is `o_vec[k*IN_W +: IN_W]`, which drives tree input `i_k`.
- `err_len`  out  1  one-cycle pulse on frame-length error.

## Operation
- States:
  - COLLECT: gathering a frame.
  - DRAIN: discarding bytes until `s_last` arrives.
- Byte index `idx` runs 0..N_IN-1, with width clog2(N_IN). Each accepted byte in COLLECT is written to `buf[idx]`.
- COLLECT, accept with `idx < N_IN-1`:
  - `s_last`=0: `idx` increments.
  - `s_last`=1: short frame. Pulse `err_len`, set `idx` to 0, stay in COLLECT. No `o_valid`.
- COLLECT, accept with `idx == N_IN-1`:
  - `s_last`=1: commit. `o_vec` is loaded with the buffer contents plus the current byte, `o_valid` pulses, and `idx` returns to 0.
  - `s_last`=0: long frame. Pulse `err_len`, go to DRAIN, set `idx` to 0. No commit.
- DRAIN: accepted bytes are dropped. An accept with `s_last`=1 returns the block to COLLECT. No further `err_len` pulses are raised for the same frame.
- `s_ready` is 1 in both states; the tree never stalls. `s_ready` is 0 only while `rst` is asserted and is registered out of reset.
- `o_vec` holds the last committed frame until the next commit. Collecting a new frame never disturbs `o_vec`, because the frame buffer and the output register are separate.
- Cycles with `s_valid`=0 change nothing. Gaps inside a frame are legal.
- Reset values: `o_valid`=0, `err_len`=0, `s_ready`=0, `o_vec`=0, `idx`=0, state COLLECT. The frame buffer is not reset.
- Reset mid-frame: the partial frame is lost, and collection restarts with the first byte accepted after reset.

## Timing
- Commit or error latency: the final byte is accepted at edge T. `o_valid` or `err_len` is high for the cycle after T, then low.
- `o_vec` is valid in the same cycle as `o_valid` and remains stable afterwards.
- Throughput: 1 byte/clk sustained. Back-to-back frames are supported: frame k+1 byte 0 may be accepted on the edge immediately after frame k's last byte, giving one `o_valid` per 37 cycles.
- `o_valid` and `err_len` are never high in the same cycle.
- Downstream tree: `dout_valid`/`sum` follow `o_valid` by the tree's fixed pipeline depth. The feeder does not track that depth.

## Structure
- Shared package `adder_tree_pkg` holds:
  - `N_IN`=37, `IN_W`=8, `SUM_W`=14 (clog2(37*255+1)).
  - The state enum {COLLECT, DRAIN}.
- Single flat module with no sub-module.
- The frame buffer is a register array of N_IN×IN_W.
- `o_vec` is a separate output register loaded in one cycle.
- Integration: `adder_tree_top` instantiates `adder_tree_feeder` and `AdderTree`, slicing `o_vec` into `i_0..i_36`.

## Test plan
- Ramp frame: send bytes 0..36 with `s_last` on byte 36. Required: exactly one `o_valid` 1 cycle after the last accept; `o_vec` byte k = k; tree `sum` = 666.
- Saturated frame, then offset frame back-to-back: all bytes 255, then bytes 100+k. Required: two `o_valid` pulses 37 cycles apart; tree sums 9435, then 4366.
- Short frame: `s_last` on byte 10. Required: `err_len` pulse, no `o_valid`, `o_vec` unchanged. A following ramp frame commits correctly (sum 666).
- Long frame: 40 bytes, `s_last` on byte 40. Required: `err_len` pulse 1 cycle after byte 37 is accepted; bytes 38-40 dropped; no `o_valid`. The next ramp frame commits correctly.
- Reset mid-frame: assert `rst` for 1 cycle after 20 bytes, then send a full frame of 5s. Required: every output is at its reset value during reset; one `o_valid` with all bytes 5 (sum 185).
- Random `s_valid` gaps within a ramp frame: required result is identical to the gap-free case, with `o_valid` 1 cycle after the last accept.
